// File: rtl/song_sequencer_pkg.sv
// Shared widths, ROM word layout and FSM encoding for the song sequencer and its note ROM.
package song_sequencer_pkg;

    localparam int unsigned NOTE_W = 6;
    localparam int unsigned DUR_W  = 6;
    localparam int unsigned IDX_W  = 5;
    localparam int unsigned SONG_W = 2;
    localparam int unsigned ADDR_W = SONG_W + IDX_W;
    localparam int unsigned ROM_W  = NOTE_W + DUR_W;

    localparam int unsigned NOTE_MSB = 11;
    localparam int unsigned NOTE_LSB = 6;
    localparam int unsigned DUR_MSB  = 5;
    localparam int unsigned DUR_LSB  = 0;

    localparam logic [DUR_W-1:0] TERM_DUR = '0;
    localparam logic [IDX_W-1:0] IDX_LAST = '1;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StFetch = 3'd1,
        StLatch = 3'd2,
        StEmit  = 3'd3,
        StWait  = 3'd4,
        StNext  = 3'd5,
        StDone  = 3'd6
    } state_e;

    function automatic logic is_terminator(input logic [ROM_W-1:0] word);
        return word[DUR_MSB:DUR_LSB] == TERM_DUR;
    endfunction

endpackage

// File: rtl/song_sequencer_if.sv
// Controller / note-player / ROM signals seen by the song sequencer.
interface song_sequencer_if;
    import song_sequencer_pkg::*;

    logic              play;
    logic              reset_player;
    logic [SONG_W-1:0] song;
    logic              note_done;
    logic [ADDR_W-1:0] rom_addr;
    logic [ROM_W-1:0]  rom_data;
    logic [NOTE_W-1:0] note;
    logic [DUR_W-1:0]  duration;
    logic              new_note;
    logic              song_done;

    modport master (
        output play, reset_player, song, note_done, rom_data,
        input  rom_addr, note, duration, new_note, song_done
    );

    modport slave (
        input  play, reset_player, song, note_done, rom_data,
        output rom_addr, note, duration, new_note, song_done
    );

endinterface

// File: rtl/song_rom.sv
// 128x12 synchronous note ROM, one-cycle read latency; word = {note, duration}.
module song_rom
    import song_sequencer_pkg::*;
(
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr,
    output logic [ROM_W-1:0]  data
);

    logic [ROM_W-1:0]  data_d, data_q;
    logic [IDX_W-1:0]  idx;
    logic [NOTE_W-1:0] idx_ext;

    assign idx     = addr[IDX_W-1:0];
    assign idx_ext = NOTE_W'(idx);

    // Song 0: two notes then terminator; song 1: 32 notes, no terminator;
    // song 2: three notes then terminator; song 3: empty.
    always_comb begin
        data_d = '0;
        case (addr[ADDR_W-1:IDX_W])
            2'd0: begin
                if (idx == 5'd0) begin
                    data_d = {6'd10, 6'd4};
                end else if (idx == 5'd1) begin
                    data_d = {6'd20, 6'd8};
                end
            end
            2'd1: data_d = {idx_ext + 6'd32, idx_ext + 6'd1};
            2'd2: begin
                if (idx < 5'd3) begin
                    data_d = {idx_ext + 6'd50, 6'd3};
                end
            end
            default: data_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        data_q <= data_d;
    end

    assign data = data_q;

endmodule

// File: rtl/song_sequencer.sv
// Walks the selected song's ROM entries, strobes each note to the note player and waits for
// note_done; pulses song_done at a terminator or after the last slot.
module song_sequencer
    import song_sequencer_pkg::*;
(
    input logic             clk,
    input logic             reset,
    song_sequencer_if.slave bus
);

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [NOTE_W-1:0] note_q, note_d;
    logic [DUR_W-1:0]  dur_q, dur_d;
    logic              new_note;
    logic              song_done;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        note_d    = note_q;
        dur_d     = dur_q;
        new_note  = 1'b0;
        song_done = 1'b0;

        case (state_q)
            StIdle: begin
                if (bus.play) begin
                    state_d = StFetch;
                end
            end
            StFetch: state_d = StLatch;
            StLatch: begin
                if (is_terminator(bus.rom_data)) begin
                    state_d = StDone;
                end else begin
                    note_d  = bus.rom_data[NOTE_MSB:NOTE_LSB];
                    dur_d   = bus.rom_data[DUR_MSB:DUR_LSB];
                    state_d = StEmit;
                end
            end
            // Strobe is gated by play so a pause during the fetch holds the note back.
            StEmit: begin
                if (bus.play) begin
                    new_note = 1'b1;
                    state_d  = StWait;
                end
            end
            StWait: begin
                if (bus.note_done) begin
                    state_d = StNext;
                end
            end
            StNext: begin
                if (idx_q == IDX_LAST) begin
                    state_d = StDone;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = StIdle;
                end
            end
            StDone: begin
                song_done = 1'b1;
                idx_d     = '0;
                state_d   = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Player restart overrides everything but leaves the last note on the outputs.
        if (bus.reset_player) begin
            state_d   = StIdle;
            idx_d     = '0;
            new_note  = 1'b0;
            song_done = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            idx_q   <= '0;
            note_q  <= '0;
            dur_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            note_q  <= note_d;
            dur_q   <= dur_d;
        end
    end

    assign bus.rom_addr  = {bus.song, idx_q};
    assign bus.note      = note_q;
    assign bus.duration  = dur_q;
    assign bus.new_note  = new_note;
    assign bus.song_done = song_done;

endmodule

// File: tb/tb_song_sequencer.sv
// Bench for song_sequencer with song_rom: per-song vector table plus hand-written corner cases,
// every note/song_done pulse checked against a queue of expected events.
module tb_song_sequencer;
    import song_sequencer_pkg::*;

    typedef struct packed {
        logic       is_done;
        logic [5:0] note;
        logic [5:0] dur;
    } ev_t;

    typedef struct {
        logic [1:0] song;
        int         n_notes;
        int         first_lat;
        int         last_gap;
    } vec_t;

    logic clk;
    logic reset;
    song_sequencer_if bus();

    song_rom u_rom (
        .clk  (clk),
        .addr (bus.rom_addr),
        .data (bus.rom_data)
    );

    song_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   checks;
    int   errors;
    logic prev_pulse;
    ev_t  exp_q[$];
    vec_t vecs[4];

    // Expected ROM contents for each song slot.
    function automatic ev_t note_ev(input int s, input int i);
        ev_t e;
        e = '0;
        if (s == 0 && i == 0) e = {1'b0, 6'd10, 6'd4};
        if (s == 0 && i == 1) e = {1'b0, 6'd20, 6'd8};
        if (s == 1) e = {1'b0, 6'(32 + i), 6'(i + 1)};
        if (s == 2) e = {1'b0, 6'(50 + i), 6'd3};
        return e;
    endfunction

    function automatic ev_t done_ev();
        ev_t e;
        e = '0;
        e.is_done = 1'b1;
        return e;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic monitor();
        ev_t  e;
        logic pulse;
        pulse = bus.new_note | bus.song_done;
        if (reset) begin
            prev_pulse = 1'b0;
            return;
        end
        if (pulse) begin
            checks++;
            if (bus.new_note && bus.song_done) begin
                errors++;
                $display("FAIL pulse_overlap: new_note and song_done both high (t=%0t)", $time);
            end else if (prev_pulse) begin
                errors++;
                $display("FAIL pulse_back_to_back: pulse on consecutive cycles (t=%0t)", $time);
            end else if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse: new_note=%0b song_done=%0b, none expected (t=%0t)",
                         bus.new_note, bus.song_done, $time);
            end else begin
                e = exp_q.pop_front();
                if (e.is_done !== bus.song_done ||
                    (!e.is_done && (e.note !== bus.note || e.dur !== bus.duration))) begin
                    errors++;
                    $display("FAIL scoreboard: got done=%0b note=%0d dur=%0d, expected done=%0b note=%0d dur=%0d (t=%0t)",
                             bus.song_done, bus.note, bus.duration, e.is_done, e.note, e.dur, $time);
                end
            end
        end
        prev_pulse = pulse;
    endtask

    // Sample on the falling edge, then land just after the next rising edge to drive inputs.
    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic restart(input logic [1:0] s);
        bus.reset_player = 1'b1;
        tick();
        bus.reset_player = 1'b0;
        bus.song = s;
        tick();
    endtask

    // Follows n notes plus the closing song_done, acking each note two cycles after its strobe.
    task automatic expect_events(input int n, input int w0, input int first_gap, input int last_gap);
        int w;
        int exp_gap;
        w = w0;
        for (int i = 0; i <= n; i++) begin
            while (!(bus.new_note || bus.song_done) && w < 50) begin
                tick();
                w++;
            end
            if (!(bus.new_note || bus.song_done)) begin
                checks++;
                errors++;
                $display("FAIL event_timeout: no pulse after %0d cycles, expected event %0d of %0d",
                         w, i, n);
                bus.play = 1'b0;
                return;
            end
            exp_gap = (i == 0) ? first_gap : ((i == n) ? last_gap : 5);
            chk("pulse_latency", w, exp_gap);
            chk("pulse_kind", int'(bus.song_done), int'(i == n));
            if (i < n) begin
                tick();
                tick();
                bus.note_done = 1'b1;
                tick();
                bus.note_done = 1'b0;
                w = 1;
            end else begin
                bus.play = 1'b0;
            end
        end
    endtask

    task automatic run_vec(input vec_t v);
        restart(v.song);
        chk("start_addr", int'(bus.rom_addr), int'({v.song, 5'd0}));
        for (int i = 0; i < v.n_notes; i++) exp_q.push_back(note_ev(int'(v.song), i));
        exp_q.push_back(done_ev());
        bus.play = 1'b1;
        expect_events(v.n_notes, 0, v.first_lat, v.last_gap);
        tick();
        chk("idx_cleared", int'(bus.rom_addr), int'({v.song, 5'd0}));
    endtask

    initial begin
        int w;
        checks = 0;
        errors = 0;
        prev_pulse = 1'b0;
        reset = 1'b1;
        bus.play = 1'b0;
        bus.reset_player = 1'b0;
        bus.song = 2'd0;
        bus.note_done = 1'b0;

        vecs[0] = '{2'd0, 2, 3, 5};
        vecs[1] = '{2'd1, 32, 3, 2};
        vecs[2] = '{2'd2, 3, 3, 5};
        vecs[3] = '{2'd3, 0, 3, 3};

        tick();
        tick();
        chk("rst_note", int'(bus.note), 0);
        chk("rst_duration", int'(bus.duration), 0);
        chk("rst_new_note", int'(bus.new_note), 0);
        chk("rst_song_done", int'(bus.song_done), 0);
        chk("rst_rom_addr", int'(bus.rom_addr), 0);
        reset = 1'b0;
        tick();

        for (int k = 0; k < 4; k++) run_vec(vecs[k]);

        // Pause during FETCH: the note is fetched and held back until play returns.
        restart(2'd0);
        exp_q.push_back(note_ev(0, 0));
        bus.play = 1'b1;
        tick();
        bus.play = 1'b0;
        tick();
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("pause_hold", int'(bus.new_note), 0);
        end
        bus.play = 1'b1;
        #1;
        chk("resume_strobe", int'(bus.new_note), 1);
        chk("resume_note", int'(bus.note), 10);
        chk("resume_duration", int'(bus.duration), 4);
        tick();
        bus.play = 1'b0;
        bus.reset_player = 1'b1;
        tick();
        bus.reset_player = 1'b0;
        chk("rp_hold_note", int'(bus.note), 10);
        chk("rp_hold_duration", int'(bus.duration), 4);

        // reset_player together with the final note_done of a full song.
        restart(2'd1);
        for (int i = 0; i < 32; i++) exp_q.push_back(note_ev(1, i));
        exp_q.push_back(note_ev(2, 0));
        bus.play = 1'b1;
        for (int i = 0; i < 32; i++) begin
            w = 0;
            while (!bus.new_note && w < 20) begin
                tick();
                w++;
            end
            if (!bus.new_note) begin
                checks++;
                errors++;
                $display("FAIL full_song_timeout: note %0d missing after %0d cycles", i, w);
            end
            tick();
            tick();
            if (i < 31) begin
                bus.note_done = 1'b1;
                tick();
                bus.note_done = 1'b0;
            end
        end
        bus.note_done = 1'b1;
        bus.reset_player = 1'b1;
        #1;
        chk("rp_no_song_done", int'(bus.song_done), 0);
        tick();
        bus.note_done = 1'b0;
        bus.reset_player = 1'b0;
        bus.song = 2'd2;
        #1;
        chk("rp_idle_addr", int'(bus.rom_addr), int'({2'd2, 5'd0}));
        chk("rp_idle_no_done", int'(bus.song_done), 0);
        tick();
        chk("rp_fetch_addr", int'(bus.rom_addr), int'({2'd2, 5'd0}));
        tick();
        tick();
        chk("rp_new_song_strobe", int'(bus.new_note), 1);
        tick();
        bus.play = 1'b0;
        bus.reset_player = 1'b1;
        tick();
        bus.reset_player = 1'b0;

        // Asynchronous reset while waiting on a note.
        restart(2'd0);
        exp_q.push_back(note_ev(0, 0));
        bus.play = 1'b1;
        w = 0;
        while (!bus.new_note && w < 20) begin
            tick();
            w++;
        end
        chk("pre_reset_strobe", int'(bus.new_note), 1);
        tick();
        #2;
        reset = 1'b1;
        #1;
        chk("areset_note", int'(bus.note), 0);
        chk("areset_duration", int'(bus.duration), 0);
        chk("areset_new_note", int'(bus.new_note), 0);
        chk("areset_song_done", int'(bus.song_done), 0);
        tick();
        reset = 1'b0;
        exp_q.push_back(note_ev(0, 0));
        w = 0;
        while (!bus.new_note && w < 20) begin
            tick();
            w++;
        end
        chk("post_reset_latency", w, 3);
        tick();
        bus.play = 1'b0;
        bus.reset_player = 1'b1;
        tick();
        bus.reset_player = 1'b0;

        // Spurious note_done in IDLE, FETCH, LATCH and a paused EMIT.
        restart(2'd0);
        exp_q.push_back(note_ev(0, 0));
        exp_q.push_back(note_ev(0, 1));
        exp_q.push_back(done_ev());
        bus.note_done = 1'b1;
        tick();
        bus.play = 1'b1;
        tick();
        bus.play = 1'b0;
        tick();
        tick();
        tick();
        bus.note_done = 1'b0;
        bus.play = 1'b1;
        #1;
        expect_events(2, 0, 0, 5);

        tick();
        tick();
        chk("queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
